decode_issue: RTL

DECODE_ISSUE -- requirements
Module: decode_issue

---
 rtl/cpu_pkg.sv | 36 +++
 rtl/decode_issue_scoreboard.sv | 32 +++
 rtl/decode_issue.sv | 143 ++++++++++++++
 3 files changed

// File: rtl/cpu_pkg.sv
// Shared instruction-format definitions for the decode/issue stage:
// field positions, opcode values and the opcode classification helper.
package cpu_pkg;

  localparam int OP_HI  = 31;
  localparam int OP_LO  = 26;
  localparam int RS_HI  = 25;
  localparam int RS_LO  = 21;
  localparam int RT_HI  = 20;
  localparam int RT_LO  = 16;
  localparam int RD_HI  = 15;
  localparam int RD_LO  = 11;
  localparam int IMM_HI = 15;
  localparam int IMM_LO = 0;

  localparam logic [5:0] OP_RTYPE = 6'h00;
  localparam logic [5:0] OP_ITYPE = 6'h01;
  localparam logic [5:0] OP_STORE = 6'h02;

  typedef enum logic [1:0] {
    CLS_R,
    CLS_I,
    CLS_STORE,
    CLS_ILLEGAL
  } instr_class_e;

  function automatic instr_class_e classify(input logic [5:0] op);
    case (op)
      OP_RTYPE: return CLS_R;
      OP_ITYPE: return CLS_I;
      OP_STORE: return CLS_STORE;
      default:  return CLS_ILLEGAL;
    endcase
  endfunction

endpackage

// File: rtl/decode_issue_scoreboard.sv
// Pending-write scoreboard: one bit per architectural register, r0 never tracked.
// A set and a clear of the same bit in one cycle leaves the bit set.
module scoreboard (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        set_en,
  input  logic [4:0]  set_idx,
  input  logic        clr_en,
  input  logic [4:0]  clr_idx,
  output logic [31:0] pending
);

  logic [31:0] pending_reg;
  logic [31:0] pending_next;

  assign pending_next[0] = 1'b0;

  generate
    for (genvar gi = 1; gi < 32; gi++) begin : g_bit
      assign pending_next[gi] = (set_en && (set_idx == 5'(gi))) ||
                                (pending_reg[gi] && !(clr_en && (clr_idx == 5'(gi))));
    end
  endgenerate

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) pending_reg <= '0;
    else        pending_reg <= pending_next;
  end

  assign pending = pending_reg;

endmodule

// File: rtl/decode_issue.sv
// Single-issue decode stage: decodes one instruction, interlocks on pending
// register writes and hands a registered op to execute with valid/ready.
module decode_issue
  import cpu_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] instr,
  output logic [4:0]  rf_r1,
  output logic [4:0]  rf_r2,
  output logic        ex_valid,
  input  logic        ex_ready,
  output logic [5:0]  ex_op,
  output logic [4:0]  ex_wrn,
  output logic        ex_we,
  output logic [31:0] ex_imm,
  output logic        ex_illegal,
  input  logic        wb_valid,
  input  logic [4:0]  wb_wrn
);

  logic [5:0]   op;
  logic [4:0]   rs;
  logic [4:0]   rt;
  logic [4:0]   rd;
  logic [15:0]  imm16;
  instr_class_e cls;

  assign op    = instr[OP_HI:OP_LO];
  assign rs    = instr[RS_HI:RS_LO];
  assign rt    = instr[RT_HI:RT_LO];
  assign rd    = instr[RD_HI:RD_LO];
  assign imm16 = instr[IMM_HI:IMM_LO];
  assign cls   = classify(op);

  logic        reads_rs;
  logic        reads_rt;
  logic        writes;
  logic [4:0]  dest;
  logic [31:0] imm_ext;
  logic        illegal;

  always_comb begin
    reads_rs = 1'b0;
    reads_rt = 1'b0;
    writes   = 1'b0;
    dest     = '0;
    imm_ext  = '0;
    illegal  = 1'b0;
    case (cls)
      CLS_R: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
        writes   = 1'b1;
        dest     = rd;
      end
      CLS_I: begin
        reads_rs = 1'b1;
        writes   = 1'b1;
        dest     = rt;
        imm_ext  = {{16{imm16[15]}}, imm16};
      end
      CLS_STORE: begin
        reads_rs = 1'b1;
        reads_rt = 1'b1;
      end
      default: illegal = 1'b1;
    endcase
  end

  logic        we_dec;
  logic [31:0] pending;
  logic        hazard;
  logic        accept;

  // r0 is a hardwired zero: never a destination, never a hazard source.
  assign we_dec = writes && (dest != 5'd0);

  assign hazard = in_valid && ((reads_rs && (rs != 5'd0) && pending[rs]) ||
                               (reads_rt && (rt != 5'd0) && pending[rt]) ||
                               (we_dec && pending[dest]));

  logic        ex_valid_reg;
  logic [5:0]  ex_op_reg;
  logic [4:0]  ex_wrn_reg;
  logic        ex_we_reg;
  logic [31:0] ex_imm_reg;
  logic        ex_illegal_reg;
  logic [4:0]  ex_rs_reg;
  logic [4:0]  ex_rt_reg;

  assign in_ready = rst_n && !hazard && (!ex_valid_reg || ex_ready);
  assign accept   = in_valid && in_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ex_valid_reg   <= 1'b0;
      ex_op_reg      <= '0;
      ex_wrn_reg     <= '0;
      ex_we_reg      <= 1'b0;
      ex_imm_reg     <= '0;
      ex_illegal_reg <= 1'b0;
      ex_rs_reg      <= '0;
      ex_rt_reg      <= '0;
    end else if (accept) begin
      ex_valid_reg   <= 1'b1;
      ex_op_reg      <= op;
      ex_wrn_reg     <= dest;
      ex_we_reg      <= we_dec;
      ex_imm_reg     <= imm_ext;
      ex_illegal_reg <= illegal;
      ex_rs_reg      <= rs;
      ex_rt_reg      <= rt;
    end else if (ex_ready) begin
      ex_valid_reg   <= 1'b0;
    end
  end

  // Register-file addresses follow the op that will sit in the ex stage,
  // so read data stays aligned with ex_valid through stalls.
  assign rf_r1 = accept ? rs : ex_rs_reg;
  assign rf_r2 = accept ? rt : ex_rt_reg;

  scoreboard u_sb (
    .clk     (clk),
    .rst_n   (rst_n),
    .set_en  (accept && we_dec),
    .set_idx (dest),
    .clr_en  (wb_valid),
    .clr_idx (wb_wrn),
    .pending (pending)
  );

  assign ex_valid   = ex_valid_reg;
  assign ex_op      = ex_op_reg;
  assign ex_wrn     = ex_wrn_reg;
  assign ex_we      = ex_we_reg;
  assign ex_imm     = ex_imm_reg;
  assign ex_illegal = ex_illegal_reg;

endmodule
